// File: rtl/pc_seq_ctrl_pkg.sv
// Shared pipeline definitions for the PC sequencer: state and redirect-priority
// encodings, default vectors and the redirect payload.
package pc_seq_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  localparam logic [XLEN-1:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] EXC_VEC_DEF   = 32'h0000_0080;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } pc_state_e;

  // Higher value wins; NONE must stay lowest so any valid redirect beats it
  typedef enum logic [1:0] {
    PRI_NONE = 2'd0,
    PRI_JMP  = 2'd1,
    PRI_BR   = 2'd2,
    PRI_EXC  = 2'd3
  } redir_pri_e;

  typedef struct packed {
    logic            valid;
    redir_pri_e      pri;
    logic [XLEN-1:0] target;
  } redirect_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Combinational redirect arbiter: picks exception > branch > jump and returns
// the word-aligned target, its priority and whether the raw target was misaligned.
module pc_redirect_sel
  import pc_seq_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] EXC_VEC = EXC_VEC_DEF
) (
  input  logic            exc_req,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp,
  input  logic [XLEN-1:0] jmp_target,
  output redirect_t       redir_c,
  output logic            misalign_c
);

  always_comb begin
    redir_c    = '0;
    misalign_c = 1'b0;
    if (exc_req) begin
      redir_c.valid  = 1'b1;
      redir_c.pri    = PRI_EXC;
      redir_c.target = align_word(EXC_VEC);
      misalign_c     = |EXC_VEC[1:0];
    end else if (br_taken) begin
      redir_c.valid  = 1'b1;
      redir_c.pri    = PRI_BR;
      redir_c.target = align_word(br_target);
      misalign_c     = |br_target[1:0];
    end else if (jmp) begin
      redir_c.valid  = 1'b1;
      redir_c.pri    = PRI_JMP;
      redir_c.target = align_word(jmp_target);
      misalign_c     = |jmp_target[1:0];
    end
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer: selects the next fetch address, holds a pending redirect
// across instruction-memory wait states, and handles halt/resume and flushes.
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [XLEN-1:0] EXC_VEC   = EXC_VEC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc_cur,
  output logic [XLEN-1:0]   pc_in,
  output logic              imem_req,
  input  logic              imem_ready,
  input  logic              stall_id,
  input  logic              br_taken_ex,
  input  logic [XLEN-1:0]   br_target_ex,
  input  logic              jmp_id,
  input  logic [XLEN-1:0]   jmp_target_id,
  input  logic              exc_req,
  input  logic              halt,
  input  logic              resume,
  output logic              flush_if,
  output logic              flush_id,
  output logic              align_err,
  output logic [CNT_W-1:0]  stall_cnt
);

  pc_state_e       state_q, state_d;
  redirect_t       pend_q, pend_d;
  redirect_t       live_c;
  logic            live_misalign_c;
  logic            take_live_c;
  logic            stall_inc_c;
  logic [XLEN-1:0] pc_seq_c;

  pc_redirect_sel #(.EXC_VEC(EXC_VEC)) u_sel (
    .exc_req    (exc_req),
    .br_taken   (br_taken_ex),
    .br_target  (br_target_ex),
    .jmp        (jmp_id),
    .jmp_target (jmp_target_id),
    .redir_c    (live_c),
    .misalign_c (live_misalign_c)
  );

  assign pc_seq_c = pc_cur + XLEN'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // take_live_c marks the cycle a live redirect is applied or latched; flushes fire then
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pc_in       = RESET_VEC;
    imem_req    = 1'b0;
    take_live_c = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        imem_req = 1'b1;
        if (!imem_ready) begin
          pc_in   = pc_cur;
          state_d = ST_WAIT;
          if (live_c.valid) begin
            pend_d      = live_c;
            take_live_c = 1'b1;
          end
        end else if (live_c.valid && (live_c.pri != PRI_JMP)) begin
          pc_in       = live_c.target;
          take_live_c = 1'b1;
        end else if (halt) begin
          pc_in   = pc_seq_c;
          state_d = ST_HALT;
        end else if (live_c.valid) begin
          pc_in       = live_c.target;
          take_live_c = 1'b1;
        end else if (stall_id) begin
          pc_in = pc_cur;
        end else begin
          pc_in = pc_seq_c;
        end
      end
      ST_WAIT: begin
        imem_req = 1'b1;
        if (!imem_ready) begin
          pc_in = pc_cur;
          if (live_c.valid && (live_c.pri >= pend_q.pri)) begin
            pend_d      = live_c;
            take_live_c = 1'b1;
          end
        end else begin
          state_d = ST_RUN;
          pend_d  = '0;
          if (live_c.valid && (live_c.pri >= pend_q.pri)) begin
            pc_in       = live_c.target;
            take_live_c = 1'b1;
          end else if (pend_q.valid) begin
            pc_in = pend_q.target;
          end else begin
            pc_in = pc_seq_c;
          end
        end
      end
      ST_HALT: begin
        pc_in = pc_cur;
        if (exc_req) begin
          pc_in       = live_c.target;
          take_live_c = 1'b1;
          state_d     = ST_RUN;
        end else if (resume) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
    flush_if    = take_live_c;
    flush_id    = take_live_c && (live_c.pri != PRI_JMP);
    stall_inc_c = ((state_q == ST_RUN) || (state_q == ST_WAIT)) && (pc_in == pc_cur);
  end

  // Sticky alignment flag and saturating hold counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      align_err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (take_live_c && live_misalign_c) begin
        align_err <= 1'b1;
      end
      if (stall_inc_c && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 Parameter: RESET_VEC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: EXC_VEC, 32'h0000_0080, exception handler address.
REQ-003 Port: clk  in  1  clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: pc_cur  in  32  current registered PC, fed back from the PC register.
REQ-006 Port: pc_in  out  32  next PC value, captured by the PC register on the next clk edge.
REQ-007 Port: imem_req  out  1  fetch request to instruction memory.
REQ-008 Port: imem_ready  in  1  instruction memory accepted the fetch at pc_cur this cycle.
REQ-009 Port: stall_id  in  1  load-use hazard from ID; hold the PC.
REQ-010 Port: br_taken_ex / br_target_ex  in  1/32  taken branch resolved in EX, with its target.
REQ-011 Port: jmp_id / jmp_target_id  in  1/32  jump (J/JAL/JR) decoded in ID, with its target.
REQ-012 Port: exc_req  in  1  exception request; redirect to EXC_VEC.
REQ-013 Port: halt / resume  in  1/1  stop fetching / restart fetching.
REQ-014 Port: flush_if / flush_id  out  1/1  squash the IF/ID or ID/EX pipeline register.
REQ-015 Port: align_err  out  1  sticky flag: a redirect target had bits [1:0] != 0.
REQ-016 Port: stall_cnt  out  16  saturating count of PC-hold cycles.

Function
REQ-017 The controller SHALL implement the states BOOT, RUN, WAIT and HALT.
REQ-018 pc_in, imem_req, flush_if and flush_id SHALL be combinational from the state and the inputs; all other outputs SHALL be registered.
REQ-019 BOOT: pc_in=RESET_VEC, imem_req=0; the next state SHALL be RUN unconditionally.
REQ-020 RUN with imem_ready=1: imem_req=1, and pc_in SHALL follow this priority: exc_req -> EXC_VEC; br_taken_ex -> br_target_ex; jmp_id -> jmp_target_id; stall_id -> pc_cur; otherwise pc_cur+4.
REQ-021 pc_cur+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC steps to 32'h0000_0000.
REQ-022 Redirect targets SHALL have bits [1:0] forced to 0; if the raw bits were nonzero, align_err SHALL be set and held until reset.
REQ-023 An exc_req or br_taken_ex redirect SHALL assert flush_if and flush_id in the same cycle.
REQ-024 A jmp_id redirect SHALL assert flush_if only.
REQ-025 br_taken_ex SHALL override stall_id in the same cycle.
REQ-026 RUN with imem_ready=0: pc_in=pc_cur and the next state SHALL be WAIT.
REQ-027 Any redirect present in that RUN cycle SHALL be latched into a pending register (valid bit + target).
REQ-028 WAIT: imem_req=1 and pc_in=pc_cur while imem_ready=0.
REQ-029 In WAIT, a newly arriving redirect SHALL overwrite the pending one only if its priority is equal or higher.
REQ-030 WAIT with imem_ready=1: pc_in SHALL be the higher-priority of the pending target and the current-cycle redirect, else pc_cur+4; pending SHALL be cleared and the next state SHALL be RUN.
REQ-031 Flushes for a latched redirect SHALL assert in the cycle the redirect was latched, not when it is applied.
REQ-032 halt=1 in RUN with imem_ready=1 and no exc_req or br_taken_ex: pc_in=pc_cur+4 and the next state SHALL be HALT.
REQ-033 HALT: imem_req=0 and pc_in=pc_cur.
REQ-034 In HALT, exc_req SHALL set pc_in=EXC_VEC and move to RUN; otherwise resume SHALL move to RUN.
REQ-035 stall_cnt SHALL increment by 1 in every RUN or WAIT cycle where pc_in=pc_cur; it SHALL saturate at 16'hFFFF.

Reset
REQ-036 On rst: state=BOOT, pending cleared, align_err=0, stall_cnt=0.
REQ-037 While rst=1: pc_in=RESET_VEC, imem_req=0, flush_if=0, flush_id=0.
REQ-038 rst asserted in WAIT or HALT SHALL discard pending redirects; the first fetch after reset is always RESET_VEC.

Structure
REQ-039 The state encoding, the redirect-priority encoding and the EXC_VEC default SHALL live in the shared pipeline package.
REQ-040 Priority selection SHALL be a combinational sub-module, pc_redirect_sel: it takes the redirect requests and targets and returns valid, target and priority, and is used both for the live path and for the pending-overwrite comparison.

Verification
REQ-041 Reset release, imem_ready=1 -> pc_in: BOOT RESET_VEC, then 0x0, 0x4, 0x8, ...; stall_cnt=0.
REQ-042 stall_id=1 for 2 cycles at pc_cur=0x10 -> pc_in=0x10 twice, then 0x14; stall_cnt=2.
REQ-043 stall_id=1, br_taken_ex=1, target 0x200, same cycle -> pc_in=0x200, flush_if=flush_id=1.
REQ-044 imem_ready=0 for 3 cycles with jmp_id to 0x40 in the first cycle -> PC held, flush_if pulses once, 0x40 applied when ready returns.
REQ-045 br_target_ex=0x102 -> pc_in=0x100, align_err=1 until reset.
REQ-046 halt, then exc_req while in HALT -> imem_req=0 during HALT; pc_in=0x80; RUN resumes at 0x80, 0x84.
